// File: rtl/sync_filter_pkg.sv
// Shared helpers for the sync_filter block.
package sync_filter_pkg;

  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: STAGES-deep synchronizer, stability filter and edge pulses.
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int unsigned STAGES        = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter logic        RESET_VALUE   = 1'b0
) (
  input  logic dest_clk,
  input  logic rst,
  input  logic din,
  input  logic bypass,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic edge_nxt
);

  localparam int unsigned   CW  = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LIM = CW'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  logic [CW-1:0] cnt_q;
  logic          q_q;
  logic          rise_q;
  logic          fall_q;
  logic          s;
  logic [CW-1:0] lim;
  logic          commit;

  assign s = sync_q[STAGES-1];

  always_comb begin
    lim    = bypass ? '0 : LIM;
    commit = (s != q_q) && (cnt_q >= lim);
  end

  always_ff @(posedge dest_clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  // The counter only runs while s disagrees with q; any return to agreement restarts it.
  always_ff @(posedge dest_clk) begin
    if (rst) begin
      q_q    <= RESET_VALUE;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= commit & s;
      fall_q <= commit & ~s;
      if (commit) begin
        q_q <= s;
      end
      if ((s == q_q) || commit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign dout     = q_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_nxt = commit;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchronizer with per-channel glitch filter and edge pulses.
module sync_filter #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      STAGES        = 2,
  parameter int unsigned      FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             dest_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             bypass,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("sync_filter: FILTER_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] edge_nxt;
  logic             any_edge_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES       (STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VALUE  (RESET_VALUE[i])
    ) u_chan (
      .dest_clk(dest_clk),
      .rst     (rst),
      .din     (din[i]),
      .bypass  (bypass),
      .dout    (dout[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .edge_nxt(edge_nxt[i])
    );
  end

  // Built from the channels' next-state so it lands in the same cycle as rise/fall.
  always_ff @(posedge dest_clk) begin
    if (rst) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |edge_nxt;
    end
  end

  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_sync_filter.sv
// Scoreboard bench for sync_filter: directed scenarios plus randomized din/bypass/rst.
module tb_sync_filter;

  localparam int unsigned W  = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned FC = 4;
  localparam logic [W-1:0] RV = 4'h0;

  typedef struct packed {
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
  } exp_t;

  logic         dest_clk = 1'b0;
  logic         rst      = 1'b1;
  logic [W-1:0] din      = '0;
  logic         bypass   = 1'b0;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_edge;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit done   = 0;

  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] mq;
  int           streak[W];

  sync_filter #(
    .WIDTH        (W),
    .STAGES       (ST),
    .FILTER_CYCLES(FC),
    .RESET_VALUE  (RV)
  ) dut (
    .dest_clk(dest_clk),
    .rst     (rst),
    .din     (din),
    .bypass  (bypass),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  always #5 dest_clk = ~dest_clk;

  // Reference: s is din delayed by ST edges; q follows s once it has disagreed for `need` edges.
  task automatic model_step(input logic [W-1:0] d, input logic b, input logic r);
    exp_t         e;
    logic [W-1:0] s;
    logic [W-1:0] rr;
    logic [W-1:0] ff;
    int           need;
    rr   = '0;
    ff   = '0;
    need = b ? 1 : int'(FC);
    if (r) begin
      hist.delete();
      for (int k = 0; k < int'(ST); k++) hist.push_back(RV);
      mq = RV;
      for (int i = 0; i < int'(W); i++) streak[i] = 0;
    end else begin
      s = hist[ST-1];
      hist.push_front(d);
      void'(hist.pop_back());
      for (int i = 0; i < int'(W); i++) begin
        if (s[i] == mq[i]) begin
          streak[i] = 0;
        end else begin
          streak[i]++;
          if (streak[i] >= need) begin
            mq[i]     = s[i];
            streak[i] = 0;
            if (s[i]) rr[i] = 1'b1;
            else      ff[i] = 1'b1;
          end
        end
      end
    end
    e.dout = mq;
    e.rise = rr;
    e.fall = ff;
    e.any  = |(rr | ff);
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs (called at a negedge), record expectation, advance to next negedge.
  task automatic step(input logic [W-1:0] d, input logic b, input logic r);
    din    = d;
    bypass = b;
    rst    = r;
    model_step(d, b, r);
    @(negedge dest_clk);
  endtask

  task automatic hold(input logic [W-1:0] d, input logic b, input int n);
    for (int k = 0; k < n; k++) step(d, b, 1'b0);
  endtask

  // Monitor: one expected response per active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge dest_clk);
      #1;
      cycle++;
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cycle);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (dout !== e.dout || rise !== e.rise || fall !== e.fall || any_edge !== e.any) begin
          errors++;
          $display("FAIL outputs cycle %0d: got dout=%h rise=%h fall=%h any=%b, want dout=%h rise=%h fall=%h any=%b",
                   cycle, dout, rise, fall, any_edge, e.dout, e.rise, e.fall, e.any);
        end
      end
    end
  end

  initial begin
    int           lat;
    int           len;
    logic [W-1:0] d;
    logic         b;
    logic         r;
    for (int k = 0; k < int'(ST); k++) hist.push_back(RV);
    mq = RV;
    for (int i = 0; i < int'(W); i++) streak[i] = 0;

    // Reset with din high, then measure release-to-dout latency.
    for (int k = 0; k < 3; k++) step(4'hF, 1'b0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(4'hF, 1'b0, 1'b0);
      if (dout === 4'hF) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL release_latency: got %0d edges, want 6", lat);
    end
    hold(4'hF, 1'b0, 3);

    // Glitch on din[0] shorter than FC, then an accepted 4-cycle pulse.
    step(4'h0, 1'b0, 1'b1);
    hold(4'h0, 1'b0, 6);
    hold(4'h1, 1'b0, 3);
    hold(4'h0, 1'b0, 8);
    hold(4'h1, 1'b0, 4);
    hold(4'h0, 1'b0, 10);

    // Bypass: single-cycle pulse on din[1] passes through.
    hold(4'h2, 1'b1, 1);
    hold(4'h0, 1'b1, 6);

    // Reset mid-count on din[2].
    hold(4'h0, 1'b0, 4);
    hold(4'h4, 1'b0, 4);
    step(4'h4, 1'b0, 1'b1);
    hold(4'h4, 1'b0, 10);

    // Simultaneous swaps across channels.
    step(4'h0, 1'b0, 1'b1);
    hold(4'hA, 1'b0, 10);
    hold(4'h5, 1'b0, 10);

    // Bypass asserted while din[3] is mid-count.
    hold(4'h0, 1'b0, 10);
    hold(4'h8, 1'b0, 4);
    hold(4'h8, 1'b1, 5);
    hold(4'h8, 1'b0, 4);

    // Randomized: variable hold lengths, occasional glitches, bypass toggles and resets.
    d = '0;
    b = 1'b0;
    for (int n = 0; n < 300; n++) begin
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 3) == 0) d = d ^ W'($urandom);
      else                           d = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = ~b;
      r = ($urandom_range(0, 40) == 0);
      step(d, b, r);
      hold(d, b, len - 1);
    end

    done = 1;
    repeat (3) @(negedge dest_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
